booth_seq_mul: RTL and testbench

- Parametrised, iterative radix-4 Booth multiplier for the datapath MUL path.
- Successor to the combinational 32-bit Booth multiplier, adding:
  - configurable operand width;
  - a signed/unsigned mode select;
  - a start/busy/done handshake, so the control unit can stall for a fixed, known latency instead of tolerating a long combinational path.
- Sits between the register-file operand latches and the HI/LO product registers.

---
 rtl/booth_seq_mul.sv | 124 ++++++++++++
 tb/tb_booth_seq_mul.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/booth_seq_mul.sv
// Iterative radix-4 Booth multiplier with a start/busy/done handshake.
// Operands are extended to WIDTH+2 bits (sign or zero), so one signed Booth
// recoding serves both modes. The result appears a fixed STEPS cycles after start.
module booth_seq_mul #(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 signed_mode,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam int STEPS = WIDTH / 2 + 1;   // radix-4 digits of the extended multiplier
   localparam int AW    = WIDTH + 2;       // extended operand width
   localparam int HW    = AW + 2;          // accumulator high half, room for +/-2A
   localparam int CW    = $clog2(STEPS);

   typedef enum logic {IDLE, CALC} state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [AW-1:0]        mcand_q, mcand_d;   // extended multiplicand
   logic [HW-1:0]        hi_q, hi_d;         // accumulator high half
   logic [AW-1:0]        mlt_q, mlt_d;       // multiplier, shifted out as product low half fills in
   logic                 prev_q, prev_d;     // b[2i-1] of the current triplet
   logic [2*WIDTH-1:0]   product_q, product_d;
   logic                 done_q, done_d;

   // Booth step datapath
   logic [2:0]           trip;
   logic [HW-1:0]        a_ext, a_dbl, pp, sum;
   logic signed [HW+AW-1:0] shifted;

   // Select the Booth partial product and perform one add / arithmetic shift-by-2
   always_comb begin
      trip  = {mlt_q[1:0], prev_q};
      a_ext = {{2{mcand_q[AW-1]}}, mcand_q};
      a_dbl = a_ext << 1;
      case (trip)
         3'b001, 3'b010: pp = a_ext;
         3'b011:         pp = a_dbl;
         3'b100:         pp = -a_dbl;
         3'b101, 3'b110: pp = -a_ext;
         default:        pp = '0;
      endcase
      sum     = hi_q + pp;
      shifted = $signed({sum, mlt_q}) >>> 2;
   end

   // State and datapath registers; reset abandons any operation in flight
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         mcand_q   <= '0;
         hi_q      <= '0;
         mlt_q     <= '0;
         prev_q    <= 1'b0;
         product_q <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         mcand_q   <= mcand_d;
         hi_q      <= hi_d;
         mlt_q     <= mlt_d;
         prev_q    <= prev_d;
         product_q <= product_d;
         done_q    <= done_d;
      end
   end

   // Next-state logic: accept start in IDLE, iterate STEPS times in CALC
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      mcand_d   = mcand_q;
      hi_d      = hi_q;
      mlt_d     = mlt_q;
      prev_d    = prev_q;
      product_d = product_q;
      done_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               // The extension captures signed_mode; no separate copy is needed.
               mcand_d = signed_mode ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
               mlt_d   = signed_mode ? {{2{b[WIDTH-1]}}, b} : {2'b00, b};
               hi_d    = '0;
               prev_d  = 1'b0;
               cnt_d   = '0;
               state_d = CALC;
            end
         end
         CALC: begin
            hi_d   = shifted[HW+AW-1:AW];
            mlt_d  = shifted[AW-1:0];
            prev_d = mlt_q[1];
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == CW'(STEPS - 1)) begin
               // Low 2*WIDTH bits of {hi, mlt} hold the exact product.
               product_d = {hi_d[WIDTH-3:0], mlt_d};
               done_d    = 1'b1;
               cnt_d     = '0;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs: busy follows the state, done and product are registered
   always_comb begin
      busy    = (state_q == CALC);
      done    = done_q;
      product = product_q;
   end

endmodule

// File: tb/tb_booth_seq_mul.sv
// Directed bench for booth_seq_mul: 32-bit instance for the handshake and
// corner products, 8-bit instance for a randomised sweep against a model.
module tb_booth_seq_mul;

   logic          clk = 1'b0;
   logic          reset;
   // 32-bit instance
   logic          start32, sm32, busy32, done32;
   logic [31:0]   a32, b32;
   logic [63:0]   prod32;
   // 8-bit instance
   logic          start8, sm8, busy8, done8;
   logic [7:0]    a8, b8;
   logic [15:0]   prod8;

   int            passed = 0;
   int            total  = 0;

   always #5 clk = ~clk;

   booth_seq_mul #(.WIDTH(32)) dut32 (
      .clk(clk), .reset(reset), .start(start32), .signed_mode(sm32),
      .a(a32), .b(b32), .busy(busy32), .done(done32), .product(prod32)
   );

   booth_seq_mul #(.WIDTH(8)) dut8 (
      .clk(clk), .reset(reset), .start(start8), .signed_mode(sm8),
      .a(a8), .b(b8), .busy(busy8), .done(done8), .product(prod8)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Start one 32-bit multiply (call from IDLE or the done cycle) and wait for done.
   task automatic run32(input string tag, input logic sm, input logic [31:0] av,
                        input logic [31:0] bv, input logic [63:0] exp);
      int n;
      start32 = 1'b1; sm32 = sm; a32 = av; b32 = bv;
      tick();
      start32 = 1'b0;
      chk({tag, "_busy_hi"}, {63'b0, busy32}, 64'd1);
      n = 0;
      while (!done32 && n < 40) begin
         tick();
         n++;
      end
      chk({tag, "_latency"}, 64'(n), 64'd17);
      chk({tag, "_product"}, prod32, exp);
      chk({tag, "_busy_at_done"}, {63'b0, busy32}, 64'd0);
      $display("w32 %s sm=%0d a=%h b=%h product=%h cycles=%0d", tag, sm, av, bv, prod32, n);
   endtask

   task automatic run8(input logic sm, input logic [7:0] av, input logic [7:0] bv);
      int n;
      int sa, sb;
      logic [15:0] exp;
      sa  = sm ? int'($signed(av)) : int'(av);
      sb  = sm ? int'($signed(bv)) : int'(bv);
      exp = 16'(sa * sb);
      start8 = 1'b1; sm8 = sm; a8 = av; b8 = bv;
      tick();
      start8 = 1'b0;
      a8 = 8'($urandom); b8 = 8'($urandom); sm8 = ~sm;
      n = 0;
      while (!done8 && n < 20) begin
         tick();
         n++;
      end
      chk("w8_latency", 64'(n), 64'd5);
      chk("w8_product", {48'b0, prod8}, {48'b0, exp});
      $display("w8 sm=%0d a=%h b=%h product=%h expected=%h cycles=%0d", sm, av, bv, prod8, exp, n);
   endtask

   initial begin
      int dones, done_at;
      reset = 1'b1;
      start32 = 1'b0; sm32 = 1'b0; a32 = '0; b32 = '0;
      start8  = 1'b0; sm8  = 1'b0; a8  = '0; b8  = '0;
      tick(); tick();
      reset = 1'b0;
      chk("reset_busy", {63'b0, busy32}, 64'd0);
      chk("reset_done", {63'b0, done32}, 64'd0);
      chk("reset_product", prod32, 64'd0);
      tick();

      // Back-to-back signed operations, each started in the previous done cycle
      run32("s65x200", 1'b1, 32'd65, 32'd200, 64'd13000);
      run32("s1x1", 1'b1, 32'd1, 32'd1, 64'd1);
      run32("sm5x8", 1'b1, 32'hFFFF_FFFB, 32'd8, 64'hFFFF_FFFF_FFFF_FFD8);
      run32("sm10xm6", 1'b1, 32'hFFFF_FFF6, 32'hFFFF_FFFA, 64'd60);

      // Unsigned vs signed all-ones, and most-negative corners
      run32("uffxff", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
      run32("sffxff", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001);
      run32("smin_sq", 1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
      run32("sminxmax", 1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 64'hC000_0000_8000_0000);
      run32("zero", 1'b0, 32'd0, 32'h1234_5678, 64'd0);
      tick();

      // Start ignored while busy; operand changes mid-CALC have no effect
      start32 = 1'b1; sm32 = 1'b0; a32 = 32'd7; b32 = 32'd9;
      tick();
      start32 = 1'b0;
      dones = 0; done_at = 0;
      for (int c = 1; c <= 25; c++) begin
         if (c == 5) begin start32 = 1'b1; a32 = 32'd3; b32 = 32'd3; end
         if (c == 6) begin start32 = 1'b0; a32 = 32'hDEAD_BEEF; b32 = 32'h0BAD_F00D; sm32 = 1'b1; end
         tick();
         if (done32) begin dones++; done_at = c; end
         if (c == 17) chk("ign_product", prod32, 64'd63);
      end
      chk("ign_done_count", 64'(dones), 64'd1);
      chk("ign_done_cycle", 64'(done_at), 64'd17);
      $display("w32 ignore_start product=%h dones=%0d at=%0d", prod32, dones, done_at);

      // Reset in the middle of CALC
      start32 = 1'b1; sm32 = 1'b0; a32 = 32'd12; b32 = 32'd12;
      tick();
      start32 = 1'b0;
      for (int c = 1; c <= 7; c++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rst_busy", {63'b0, busy32}, 64'd0);
      chk("rst_done", {63'b0, done32}, 64'd0);
      chk("rst_product", prod32, 64'd0);
      dones = 0;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (done32) dones++;
      end
      chk("rst_no_done", 64'(dones), 64'd0);
      $display("w32 mid_reset product=%h dones_after=%0d", prod32, dones);
      run32("s2x3", 1'b1, 32'd2, 32'd3, 64'd6);
      tick();

      // 8-bit instance: corners then randomised sweep in both modes
      run8(1'b1, 8'h80, 8'h80);
      run8(1'b0, 8'hFF, 8'hFF);
      run8(1'b1, 8'h80, 8'h7F);
      run8(1'b0, 8'h80, 8'h03);
      for (int k = 0; k < 1000; k++)
         run8(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
